// File: rtl/bomb_pkg.sv
// ---------------------------------------------------------------------------
// bomb_pkg
// Definitions shared by the bomb scheduler and its slot tables:
//   GRID_MIN / GRID_MAX : legal playfield coordinates (1..8 on both axes)
//   coord_t             : 4-bit cell coordinate
//   game_state_e        : game_state encodings (0 = running, others = over)
//   in_grid()           : true when a coordinate lies on the playfield
//   cell_idx()          : linear 0..63 index of an on-grid cell for the
//                         64-bit occupancy map
// ---------------------------------------------------------------------------
package bomb_pkg;

  localparam int GRID_MIN = 1;
  localparam int GRID_MAX = 8;

  typedef logic [3:0] coord_t;

  typedef enum logic [1:0] {
    GS_RUNNING   = 2'd0,
    GS_OVER_A    = 2'd1,
    GS_OVER_B    = 2'd2,
    GS_OVER_DRAW = 2'd3
  } game_state_e;

  function automatic logic in_grid(coord_t c);
    return (int'(c) >= GRID_MIN) && (int'(c) <= GRID_MAX);
  endfunction

  // Only meaningful for on-grid cells; off-grid values wrap harmlessly
  // because callers never act on them.
  function automatic logic [5:0] cell_idx(coord_t x, coord_t y);
    return (6'(y) - 6'd1) * 6'd8 + (6'(x) - 6'd1);
  endfunction

endpackage

// File: rtl/bomb_slot_table.sv
// ---------------------------------------------------------------------------
// bomb_slot_table
// One player's live bombs: MAX_BOMBS slots, each holding a cell and a fuse
// counter. Every tick each live fuse counts down; a slot whose fuse reaches
// zero is freed and its cell is reported on clr_mask for that same tick.
// A grant loads the lowest free slot as it stood before this tick's
// expiries, so a slot freed at tick N is reusable only from tick N+1.
//
// Ports:
//   bombClk            in   game tick clock
//   rst                in   synchronous active-high reset
//   grant              in   load a new bomb this tick (never asserted when full)
//   grant_x, grant_y   in   cell of the new bomb
//   live               out  registered live bomb count
//   full               out  live count has reached MAX_BOMBS
//   clr_mask           out  one-hot-per-cell map of bombs expiring this tick
// ---------------------------------------------------------------------------
module bomb_slot_table
  import bomb_pkg::*;
#(
  parameter int MAX_BOMBS  = 2,
  parameter int FUSE_TICKS = 3
) (
  input  logic        bombClk,
  input  logic        rst,
  input  logic        grant,
  input  coord_t      grant_x,
  input  coord_t      grant_y,
  output logic [1:0]  live,
  output logic        full,
  output logic [63:0] clr_mask
);

  localparam int FW = $clog2(FUSE_TICKS + 1);
  localparam int IW = (MAX_BOMBS > 1) ? $clog2(MAX_BOMBS) : 1;

  typedef struct packed {
    logic          valid;
    coord_t        x;
    coord_t        y;
    logic [FW-1:0] fuse;
  } slot_t;

  slot_t          slot_q [MAX_BOMBS];
  slot_t          slot_d [MAX_BOMBS];
  logic [1:0]     live_q, live_d;
  logic [1:0]     n_exp;
  logic           found;
  logic [IW-1:0]  free_idx;

  always_comb begin
    slot_d   = slot_q;
    clr_mask = '0;
    n_exp    = '0;
    found    = 1'b0;
    free_idx = '0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (slot_q[i].valid) begin
        if (slot_q[i].fuse == FW'(1)) begin
          slot_d[i].valid = 1'b0;
          slot_d[i].fuse  = '0;
          clr_mask[cell_idx(slot_q[i].x, slot_q[i].y)] = 1'b1;
          n_exp = n_exp + 2'd1;
        end else begin
          slot_d[i].fuse = slot_q[i].fuse - FW'(1);
        end
      end else if (!found) begin
        found    = 1'b1;
        free_idx = IW'(i);
      end
    end
    if (grant && found) begin
      slot_d[free_idx].valid = 1'b1;
      slot_d[free_idx].x     = grant_x;
      slot_d[free_idx].y     = grant_y;
      slot_d[free_idx].fuse  = FW'(FUSE_TICKS);
    end
    live_d = live_q - n_exp + {1'b0, grant && found};
  end

  always_ff @(posedge bombClk) begin
    if (rst) begin
      for (int i = 0; i < MAX_BOMBS; i++) slot_q[i] <= '0;
      live_q <= '0;
    end else begin
      slot_q <= slot_d;
      live_q <= live_d;
    end
  end

  assign live = live_q;
  assign full = (live_q == 2'(MAX_BOMBS));

endmodule

// File: rtl/bomb_scheduler.sv
// ---------------------------------------------------------------------------
// bomb_scheduler
// Arbitrates bomb-place requests from two players against the grid bounds,
// each player's live-bomb limit and a shared 64-cell occupancy map. When
// both players legally ask for the same free cell, rr_pri picks the winner
// and then flips. All outputs are registered: a request sampled on a tick
// is answered by the grant/reject pulse visible after that tick.
//
// Ports:
//   bombClk, rst                   game tick clock, synchronous active-high reset
//   reqA/reqB                      bomb-place requests (level, sampled per tick)
//   reqA_x/_y, reqB_x/_y           requested cells
//   game_state                     0 = running, nonzero = game over
//   bombA_v/bombB_v                one-tick grant pulses
//   bombA_x/_y, bombB_x/_y         last granted cells
//   rejA/rejB                      one-tick reject pulses
//   liveA/liveB                    live bomb counts
//   rr_pri                         contested-cell priority (0 = A, 1 = B)
//
// Build option: define BOMB_SCHED_COOLDOWN_EN to reject a player's request
// on the tick directly after that player's grant.
// ---------------------------------------------------------------------------
module bomb_scheduler
  import bomb_pkg::*;
#(
  parameter int MAX_BOMBS  = 2,
  parameter int FUSE_TICKS = 3
) (
  input  logic       bombClk,
  input  logic       rst,
  input  logic       reqA,
  input  logic       reqB,
  input  coord_t     reqA_x,
  input  coord_t     reqA_y,
  input  coord_t     reqB_x,
  input  coord_t     reqB_y,
  input  logic [1:0] game_state,
  output logic       bombA_v,
  output logic       bombB_v,
  output coord_t     bombA_x,
  output coord_t     bombA_y,
  output coord_t     bombB_x,
  output coord_t     bombB_y,
  output logic       rejA,
  output logic       rejB,
  output logic [1:0] liveA,
  output logic [1:0] liveB,
  output logic       rr_pri
);

  logic [63:0] occ_q, occ_d;
  logic        rr_q, rr_d;
  logic        a_v_q, a_v_d, b_v_q, b_v_d;
  logic        a_rej_q, a_rej_d, b_rej_q, b_rej_d;
  coord_t      a_x_q, a_x_d, a_y_q, a_y_d;
  coord_t      b_x_q, b_x_d, b_y_q, b_y_d;

  logic [5:0]  idx_a, idx_b;
  logic        ok_a, ok_b, cool_a, cool_b;
  logic        full_a, full_b;
  logic [63:0] clr_a, clr_b;

  bomb_slot_table #(.MAX_BOMBS(MAX_BOMBS), .FUSE_TICKS(FUSE_TICKS)) u_slots_a (
    .bombClk (bombClk),
    .rst     (rst),
    .grant   (a_v_d),
    .grant_x (reqA_x),
    .grant_y (reqA_y),
    .live    (liveA),
    .full    (full_a),
    .clr_mask(clr_a)
  );

  bomb_slot_table #(.MAX_BOMBS(MAX_BOMBS), .FUSE_TICKS(FUSE_TICKS)) u_slots_b (
    .bombClk (bombClk),
    .rst     (rst),
    .grant   (b_v_d),
    .grant_x (reqB_x),
    .grant_y (reqB_y),
    .live    (liveB),
    .full    (full_b),
    .clr_mask(clr_b)
  );

  // Legality uses the state before this tick's expiries, so a freed cell or
  // slot only becomes available to requests on the following tick.
  always_comb begin
`ifdef BOMB_SCHED_COOLDOWN_EN
    cool_a = a_v_q;
    cool_b = b_v_q;
`else
    cool_a = 1'b0;
    cool_b = 1'b0;
`endif
    idx_a = cell_idx(reqA_x, reqA_y);
    idx_b = cell_idx(reqB_x, reqB_y);
    ok_a  = reqA && in_grid(reqA_x) && in_grid(reqA_y) && !full_a && !occ_q[idx_a] && !cool_a;
    ok_b  = reqB && in_grid(reqB_x) && in_grid(reqB_y) && !full_b && !occ_q[idx_b] && !cool_b;

    a_v_d   = 1'b0;
    b_v_d   = 1'b0;
    a_rej_d = 1'b0;
    b_rej_d = 1'b0;
    rr_d    = rr_q;

    if (game_state == GS_RUNNING) begin
      if (ok_a && ok_b && (idx_a == idx_b)) begin
        a_v_d   = !rr_q;
        b_rej_d = !rr_q;
        b_v_d   = rr_q;
        a_rej_d = rr_q;
        rr_d    = !rr_q;
      end else begin
        a_v_d   = ok_a;
        a_rej_d = reqA && !ok_a;
        b_v_d   = ok_b;
        b_rej_d = reqB && !ok_b;
      end
    end

    occ_d = occ_q & ~clr_a & ~clr_b;
    if (a_v_d) occ_d = occ_d | (64'd1 << idx_a);
    if (b_v_d) occ_d = occ_d | (64'd1 << idx_b);

    a_x_d = a_v_d ? reqA_x : a_x_q;
    a_y_d = a_v_d ? reqA_y : a_y_q;
    b_x_d = b_v_d ? reqB_x : b_x_q;
    b_y_d = b_v_d ? reqB_y : b_y_q;
  end

  always_ff @(posedge bombClk) begin
    if (rst) begin
      occ_q   <= '0;
      rr_q    <= 1'b0;
      a_v_q   <= 1'b0;
      b_v_q   <= 1'b0;
      a_rej_q <= 1'b0;
      b_rej_q <= 1'b0;
      a_x_q   <= '0;
      a_y_q   <= '0;
      b_x_q   <= '0;
      b_y_q   <= '0;
    end else begin
      occ_q   <= occ_d;
      rr_q    <= rr_d;
      a_v_q   <= a_v_d;
      b_v_q   <= b_v_d;
      a_rej_q <= a_rej_d;
      b_rej_q <= b_rej_d;
      a_x_q   <= a_x_d;
      a_y_q   <= a_y_d;
      b_x_q   <= b_x_d;
      b_y_q   <= b_y_d;
    end
  end

  assign bombA_v = a_v_q;
  assign bombB_v = b_v_q;
  assign bombA_x = a_x_q;
  assign bombA_y = a_y_q;
  assign bombB_x = b_x_q;
  assign bombB_y = b_y_q;
  assign rejA    = a_rej_q;
  assign rejB    = b_rej_q;
  assign rr_pri  = rr_q;

endmodule
